// File: rtl/sonar_pdm_pkg.sv
// Shared constants and helpers for the sonar PDM drive path: default rates,
// integrator width and the full-scale / saturation limits of the modulator.
package sonar_pdm_pkg;

   localparam int CLK_DIV_DEF = 10;
   localparam int OSR_DEF     = 64;
   localparam int W_DEF       = 16;
   localparam int INTEG_EXTRA = 4;

   function automatic int integ_w(input int w);
      return w + INTEG_EXTRA;
   endfunction

   function automatic longint fs_val(input int w);
      return longint'(1) << (w - 1);
   endfunction

   function automatic longint sat_hi(input int w);
      return (longint'(1) << (integ_w(w) - 1)) - 1;
   endfunction

   function automatic longint sat_lo(input int w);
      return -(longint'(1) << (integ_w(w) - 1));
   endfunction

endpackage

// File: rtl/pdm_sdm2.sv
// Second-order sigma-delta modulator core: two saturating integrators with
// +/-FS feedback from the previous output bit, advanced once per bit_tick.
module pdm_sdm2
   import sonar_pdm_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic                clk48,
   input  logic                reset,
   input  logic                bit_tick,
   input  logic signed [W-1:0] x,
   output logic                bit_out
);
   localparam int IW = integ_w(W);
   // Two guard bits so the unclamped sums never wrap before saturation.
   localparam int SW = IW + 2;
   localparam logic signed [SW-1:0] FS     = SW'(fs_val(W));
   localparam logic signed [SW-1:0] SAT_HI = SW'(sat_hi(W));
   localparam logic signed [SW-1:0] SAT_LO = SW'(sat_lo(W));

   logic signed [IW-1:0] i1_reg, i2_reg, i1_next, i2_next;
   logic signed [SW-1:0] y, sum1, sum2;
   logic                 bit_reg;

   function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
      if (v > SAT_HI) return SAT_HI[IW-1:0];
      if (v < SAT_LO) return SAT_LO[IW-1:0];
      return v[IW-1:0];
   endfunction

   always_comb begin
      y       = bit_reg ? FS : -FS;
      sum1    = $signed({{(SW-IW){i1_reg[IW-1]}}, i1_reg})
              + $signed({{(SW-W){x[W-1]}}, x}) - y;
      i1_next = sat(sum1);
      sum2    = $signed({{(SW-IW){i2_reg[IW-1]}}, i2_reg})
              + $signed({{(SW-IW){i1_next[IW-1]}}, i1_next}) - y;
      i2_next = sat(sum2);
   end

   always_ff @(posedge clk48) begin
      if (!reset) begin
         i1_reg  <= '0;
         i2_reg  <= '0;
         bit_reg <= 1'b0;
      end else if (bit_tick) begin
         i1_reg  <= i1_next;
         i2_reg  <= i2_next;
         bit_reg <= !i2_next[IW-1];
      end
   end

   assign bit_out = bit_reg;

endmodule

// File: rtl/pdm_tx.sv
// PDM transmitter: bit-clock divider, per-sample bit counter and a 2-entry
// sample FIFO feeding the second-order modulator core.
module pdm_tx
   import sonar_pdm_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF,
   parameter int OSR     = OSR_DEF,
   parameter int W       = W_DEF
) (
   input  logic                clk48,
   input  logic                reset,
   input  logic signed [W-1:0] s_data,
   input  logic                s_valid,
   output logic                s_ready,
   output logic                pdm_clk,
   output logic                pdm_data,
   output logic                underrun
);
   localparam int HALF = CLK_DIV / 2;
   localparam int CW   = $clog2(CLK_DIV);
   localparam int BW   = $clog2(OSR);

   logic                run_reg;
   logic [CW-1:0]       cnt_reg, cnt_next;
   logic                pdm_clk_reg;
   logic [BW-1:0]       bcnt_reg;
   logic                bit_tick, boundary;
   logic signed [W-1:0] mem_reg [2];
   logic                wr_ptr_reg, rd_ptr_reg;
   logic [1:0]          count_reg, count_next;
   logic                push, pop;
   logic signed [W-1:0] cur_reg, cur_next;
   logic                underrun_reg;

   // Divider holds at 0 for the first cycle after reset so pdm_clk rises
   // on the very first edge after release.
   always_comb begin
      cnt_next = '0;
      if (run_reg && cnt_reg != CW'(CLK_DIV - 1))
         cnt_next = cnt_reg + CW'(1);
   end

   assign bit_tick   = run_reg && (cnt_next == CW'(HALF));
   assign boundary   = bit_tick && (bcnt_reg == '0);
   assign s_ready    = run_reg && (count_reg != 2'd2);
   assign push       = s_valid && s_ready;
   assign pop        = boundary && (count_reg != 2'd0);
   assign count_next = count_reg + {1'b0, push} - {1'b0, pop};
   // The popped sample drives the modulator on the boundary edge itself.
   assign cur_next   = pop ? mem_reg[rd_ptr_reg] : cur_reg;

   always_ff @(posedge clk48) begin
      if (!reset) begin
         run_reg      <= 1'b0;
         cnt_reg      <= '0;
         pdm_clk_reg  <= 1'b0;
         bcnt_reg     <= '0;
         wr_ptr_reg   <= 1'b0;
         rd_ptr_reg   <= 1'b0;
         count_reg    <= 2'd0;
         cur_reg      <= '0;
         underrun_reg <= 1'b0;
      end else begin
         run_reg     <= 1'b1;
         cnt_reg     <= cnt_next;
         pdm_clk_reg <= (cnt_next < CW'(HALF));
         if (bit_tick)
            bcnt_reg <= (bcnt_reg == BW'(OSR - 1)) ? '0 : bcnt_reg + BW'(1);
         if (push)
            wr_ptr_reg <= !wr_ptr_reg;
         if (pop)
            rd_ptr_reg <= !rd_ptr_reg;
         count_reg <= count_next;
         cur_reg   <= cur_next;
         if (boundary && count_reg == 2'd0)
            underrun_reg <= 1'b1;
      end
   end

   always_ff @(posedge clk48) begin
      if (reset && push)
         mem_reg[wr_ptr_reg] <= s_data;
   end

   pdm_sdm2 #(.W(W)) u_sdm (
      .clk48    (clk48),
      .reset    (reset),
      .bit_tick (bit_tick),
      .x        (cur_next),
      .bit_out  (pdm_data)
   );

   assign pdm_clk  = pdm_clk_reg;
   assign underrun = underrun_reg;

endmodule

// File: tb/tb_pdm_tx.sv
// Self-checking bench for pdm_tx: a timeline/arithmetic reference model of the
// divider, sample buffer and second-order modulator, compared every cycle.
module tb_pdm_tx;
   localparam int CLK_DIV = 10;
   localparam int OSR     = 64;
   localparam int W       = 16;
   localparam int HALF    = CLK_DIV / 2;
   localparam int FRAME   = OSR * CLK_DIV;
   localparam int FS      = 1 << (W - 1);
   localparam int LIM     = 1 << (W + 3);

   logic                clk48 = 1'b0;
   logic                reset = 1'b0;
   logic signed [W-1:0] s_data = '0;
   logic                s_valid = 1'b0;
   logic                s_ready, pdm_clk, pdm_data, underrun;

   pdm_tx #(.CLK_DIV(CLK_DIV), .OSR(OSR), .W(W)) dut (
      .clk48    (clk48),
      .reset    (reset),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .pdm_clk  (pdm_clk),
      .pdm_data (pdm_data),
      .underrun (underrun)
   );

   always #5 clk48 = ~clk48;

   int total = 0;
   int bad   = 0;

   // Reference model state: n = clk48 edges since reset release.
   int n;
   int mq[$];
   int x_cur, i1, i2;
   bit mbit, m_under;
   int ones_acc;
   int frames[$];
   bit took;
   bit last_tick;
   int last_k;

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, n);
      end
   endtask

   function automatic int sat(input int v);
      if (v > LIM - 1) return LIM - 1;
      if (v < -LIM) return -LIM;
      return v;
   endfunction

   task automatic model_reset();
      n = 0;
      mq.delete();
      x_cur = 0; i1 = 0; i2 = 0;
      mbit = 0; m_under = 0;
      ones_acc = 0;
   endtask

   task automatic mod_bit();
      int y;
      y    = mbit ? FS : -FS;
      i1   = sat(i1 + x_cur - y);
      i2   = sat(i2 + i1 - y);
      mbit = (i2 >= 0);
   endtask

   // One clk48 cycle: advance the model across the edge, then compare.
   task automatic step();
      bit push, tick;
      int k;
      push = reset && s_valid && (n >= 1) && (mq.size() < 2);
      tick = 0;
      k    = 0;
      @(posedge clk48);
      if (!reset) begin
         model_reset();
         push = 0;
      end else begin
         n++;
         if (n > HALF && (n - 1 - HALF) % CLK_DIV == 0) begin
            k    = (n - 1 - HALF) / CLK_DIV;
            tick = 1;
            if (k % OSR == 0) begin
               if (mq.size() > 0) x_cur = mq.pop_front();
               else m_under = 1;
            end
            mod_bit();
         end
         if (push) begin
            mq.push_back(int'(s_data));
            $display("xfer t=%0d data=0x%04h", n, s_data);
         end
      end
      took      = push;
      last_tick = tick;
      last_k    = k;
      #1;
      check("pdm_clk",  pdm_clk,  (n >= 1) ? (((n - 1) % CLK_DIV) < HALF) : 0);
      check("pdm_data", pdm_data, mbit);
      check("s_ready",  s_ready,  (n >= 1) && (mq.size() < 2));
      check("underrun", underrun, m_under);
      if (tick) begin
         ones_acc += int'(pdm_data);
         if (k % OSR == OSR - 1) begin
            frames.push_back(ones_acc);
            ones_acc = 0;
         end
      end
   endtask

   task automatic run(input int cycles);
      for (int c = 0; c < cycles; c++) step();
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      step();
      step();
      reset = 1'b1;
      frames.delete();
   endtask

   task automatic check_frames(input string tag, input int first, input int last,
                               input int lo, input int hi);
      check({tag, "_nframes"}, frames.size(), last + 1);
      for (int j = first; j <= last; j++)
         check($sformatf("%s_f%0d_ones=%0d", tag, j, frames[j]),
               (frames[j] >= lo) && (frames[j] <= hi), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int xn[$];
      int hs[$];

      model_reset();

      // Clock: divider phase and data timing from release
      do_reset();
      check("rst_ready", s_ready, 0);
      check("rst_clk", pdm_clk, 0);
      run(100);

      // Zero input: 50 % density
      do_reset();
      s_valid = 1'b1;
      s_data  = 16'sh0000;
      run(HALF + 1 + 5 * FRAME);
      check_frames("zero", 1, 4, 31, 33);

      // Positive full scale
      do_reset();
      s_valid = 1'b1;
      s_data  = 16'sh7FFF;
      run(HALF + 1 + 4 * FRAME);
      check_frames("pos_fs", 2, 3, 62, 64);

      // Negative full scale
      do_reset();
      s_valid = 1'b1;
      s_data  = -16'sh8000;
      run(HALF + 1 + 4 * FRAME);
      check_frames("neg_fs", 2, 3, 0, 2);

      // Handshake: three samples presented back to back
      do_reset();
      hs = '{32'h1000, 32'h2000, 32'h3000};
      for (int c = 0; c < 3 * FRAME; c++) begin
         s_valid = (hs.size() > 0);
         s_data  = (hs.size() > 0) ? W'(hs[0]) : '0;
         step();
         if (took) begin
            xn.push_back(n);
            void'(hs.pop_front());
         end
      end
      s_valid = 1'b0;
      check("hs_count", xn.size(), 3);
      check("hs_t0", xn[0], 2);
      check("hs_t1", xn[1], 3);
      check("hs_t2", xn[2], HALF + 2);

      // Underrun: one sample, then starve
      do_reset();
      s_valid = 1'b1;
      s_data  = 16'sh4000;
      for (int c = 0; c < HALF + 1 + 4 * FRAME; c++) begin
         step();
         if (took) s_valid = 1'b0;
         if (n == HALF + 1) check("udr_first_bnd", underrun, 0);
         if (n == HALF + 1 + FRAME) check("udr_second_bnd", underrun, 1);
      end
      check("udr_sticky", underrun, 1);
      check_frames("udr_dens", 1, 3, 46, 50);

      // Reset mid-frame with the buffer full
      do_reset();
      s_valid = 1'b1;
      s_data  = 16'sh2000;
      for (int c = 0; c < 3 * FRAME; c++) begin
         step();
         if (last_tick && last_k == OSR + 29) break;
      end
      step();
      check("mid_full", s_ready, 0);
      reset = 1'b0;
      step();
      check("mid_rst_clk", pdm_clk, 0);
      check("mid_rst_data", pdm_data, 0);
      check("mid_rst_udr", underrun, 0);
      reset   = 1'b1;
      s_valid = 1'b0;
      step();
      check("mid_rel_ready", s_ready, 1);
      check("mid_rel_clk", pdm_clk, 1);
      run(FRAME + 20);

      // Random samples with random producer gaps
      do_reset();
      for (int c = 0; c < 6 * FRAME; c++) begin
         if (!s_valid && $urandom_range(0, 399) == 0) begin
            s_valid = 1'b1;
            s_data  = ($urandom_range(0, 3) == 0) ? W'($urandom)
                                                 : W'(int'($urandom_range(0, 49152)) - 24576);
         end
         step();
         if (took) s_valid = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pdm_tx.md
# pdm_tx

PDM transmitter for the sonar test board: accepts signed PCM samples over a valid/ready handshake and emits a 1-bit pulse-density stream with its bit clock, both generated from clk48. This is the drive-side counterpart of the PDM microphone receive path. It emulates a mic into the CIC/FIR chain for in-system loopback, and can also drive a 1-bit output stage. A second-order sigma-delta modulator produces the bit stream; a 2-entry input buffer absorbs producer jitter.

## Interface
- CLK_DIV, 10: clk48 cycles per PDM bit (4.8 MHz at 48 MHz); even, ≥4.
- OSR, 64: PDM bits per input sample.
- W, 16: input sample width, signed two's complement.
- clk48  in  1  system clock, 48 MHz.
- reset  in  1  reset, synchronous, active-low; clock clk48.
- s_data  in  W  signed input sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  buffer can accept; a transfer occurs on a clk48 edge with s_valid & s_ready.
- pdm_clk  out  1  PDM bit clock, 50 % duty.
- pdm_data  out  1  PDM bit; stable around the pdm_clk rising edge.
- underrun  out  1  sticky; set when a sample boundary finds the buffer empty.

## Operation
- **Reset state** (reset low at a clk48 edge), applied at that edge:
  - pdm_clk=0, pdm_data=0, s_ready=0, underrun=0.
  - Divider and bit counters = 0; buffer empty; current sample = 0; integrators = 0.
  - s_ready rises on the first edge after reset is released.
- **Divider** cnt counts 0..CLK_DIV-1 and wraps.
  - pdm_clk = 1 for cnt in 0..CLK_DIV/2-1, else 0.
  - bit_tick is asserted when cnt == CLK_DIV/2, i.e. at the pdm_clk falling edge.
- **Bit counter** bcnt counts 0..OSR-1 and advances on each bit_tick.
  - Sample boundary = bit_tick with bcnt == 0.
  - At a boundary: the current sample ← buffer head (pop) if the buffer is non-empty.
  - If the buffer is empty: the current sample holds its previous value and underrun ← 1.
- **Buffer**: 2-entry FIFO. s_ready = !full.
  - A push and a pop on the same edge are both honoured, and occupancy is unchanged.
  - A push into a full buffer cannot occur because s_ready=0.
- **Modulator**, evaluated on each bit_tick using the current sample x (sign-extended to W+4):
  - FS = 2^(W-1); y = +FS if the previous bit was 1, else −FS.
  - i1' = sat(i1 + x − y); i2' = sat(i2 + i1' − y).
  - pdm_data ← (i2' ≥ 0).
  - sat clamps to [−2^(W+3), 2^(W+3)−1]; the integrators are W+4 bits, signed.
- **Underrun** is cleared only by reset.

## Timing
- pdm_clk period = CLK_DIV clk48 cycles; high CLK_DIV/2, low CLK_DIV/2.
- pdm_data changes only on the clk48 edge where bit_tick is high, i.e. CLK_DIV/2 cycles before the next pdm_clk rise. Setup and hold at the receiver are each half a bit period.
- Sample period = OSR·CLK_DIV = 640 clk48 cycles (75 kHz).
- Latency:
  - A sample pushed into an empty buffer reaches the modulator at the next sample boundary, ≤ 640 cycles later.
  - Its first influenced bit appears on that boundary's edge.
- s_ready deasserts on the edge that makes the buffer full, and reasserts on the edge of the pop.
- Reset asserted mid-frame: all state returns to the reset values on that edge, and any partial frame is discarded. After release, the first pdm_clk rising edge occurs on the first edge after release (cnt=0 → pdm_clk=1).

## Structure
- Shared package/header sonar_pdm_pkg holds:
  - default CLK_DIV, OSR, W;
  - the integrator width constant (W+4);
  - the FS / saturation limit functions.
- One sub-module, pdm_sdm2: second-order modulator core (x, bit_tick, reset → bit).
  - The divider, counters and FIFO stay in pdm_tx.

## Test plan
- **Clock**: run reset release then 100 clk48 cycles.
  - pdm_clk toggles every 5 cycles, first high on the first edge after release.
  - pdm_data transitions only on edges where cnt==5.
- **Zero input**: feed continuous 0x0000.
  - After frame 1, every 64-bit frame holds 32±1 ones.
  - The pattern settles to alternating 1/0.
- **Full scale**: feed continuous 0x7FFF, then 0x8000.
  - 0x7FFF: ≥62 ones per frame after the 2nd frame.
  - 0x8000: ≤2 ones per frame after the 2nd frame.
  - The integrators never exceed the saturation limits.
- **Handshake**: hold s_valid=1 with 0x1000, 0x2000, 0x3000.
  - The first two transfer on consecutive edges, then s_ready=0.
  - 0x3000 transfers on the edge of the next boundary pop.
  - Samples are consumed in order, one per 640 cycles.
- **Underrun**: push one sample 0x4000, then stop.
  - underrun=1 at the second boundary.
  - Bit density stays ≈ 75 % (0x4000 held).
  - underrun stays 1 until reset.
- **Reset mid-frame**: pull reset low at bcnt=30 with the buffer full.
  - On that edge: outputs return to reset values, the buffer is empty, and underrun=0.
  - s_ready=1 one cycle after release.
